// File: rtl/instr_fetch2.sv
// Second fetch stage: physical tag compare, way select and registered handoff to decode.
// A miss FSM stalls fetch1, requests a TLB walk or line refill, then replays the PC.
module instr_fetch2 #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 20,
  parameter int unsigned WAYS       = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_valid,
  input  logic [ADDR_WIDTH-1:0]     i_pc,
  input  logic                      i_mmu_enabled,
  input  logic                      i_itlb_hit,
  input  logic                      i_itlb_fault,
  input  logic [TAG_WIDTH-1:0]      i_itlb_ptag,
  input  logic [WAYS-1:0]           i_icache_valid,
  input  logic [WAYS*TAG_WIDTH-1:0] i_icache_tag,
  input  logic [WAYS*32-1:0]        i_icache_data,
  output logic                      o_valid,
  output logic [ADDR_WIDTH-1:0]     o_pc,
  output logic [31:0]               o_instr,
  output logic                      o_except,
  output logic [1:0]                o_except_code,
  output logic                      o_stall_req,
  output logic                      o_tlb_req,
  input  logic                      i_tlb_done,
  output logic                      o_refill_req,
  input  logic                      i_refill_ack,
  input  logic                      i_refill_done,
  output logic [ADDR_WIDTH-1:0]     o_miss_addr,
  output logic                      o_replay,
  output logic [ADDR_WIDTH-1:0]     o_replay_pc
);

  localparam int unsigned OFF_WIDTH   = ADDR_WIDTH - TAG_WIDTH;
  localparam int unsigned INSTR_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    TLB_WAIT,
    REFILL_REQ,
    REFILL_WAIT,
    REPLAY,
    DRAIN
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [TAG_WIDTH-1:0]   ptag;
  logic                   any_hit;
  logic [INSTR_WIDTH-1:0] hit_data;
  logic                   take;
  logic                   misalign;
  logic                   xlate_bad;
  logic                   tlb_miss;
  logic                   page_fault;
  logic                   cache_miss;
  logic                   hit;

  // Tag compare and way select; lowest matching way wins.
  always_comb begin
    ptag     = i_mmu_enabled ? i_itlb_ptag : i_pc[ADDR_WIDTH-1 -: TAG_WIDTH];
    any_hit  = 1'b0;
    hit_data = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!any_hit && i_icache_valid[w] &&
          (i_icache_tag[w*TAG_WIDTH +: TAG_WIDTH] == ptag)) begin
        any_hit  = 1'b1;
        hit_data = i_icache_data[w*INSTR_WIDTH +: INSTR_WIDTH];
      end
    end
  end

  // Fetch classification, only meaningful while idle and free to advance.
  always_comb begin
    take       = (state == IDLE) && i_valid && !i_stall && !i_flush;
    misalign   = take && i_pc[0];
    xlate_bad  = i_mmu_enabled && (!i_itlb_hit || i_itlb_fault);
    tlb_miss   = take && !i_pc[0] && i_mmu_enabled && !i_itlb_hit;
    page_fault = take && !i_pc[0] && i_mmu_enabled && i_itlb_hit && i_itlb_fault;
    cache_miss = take && !i_pc[0] && !xlate_bad && !any_hit;
    hit        = take && !i_pc[0] && !xlate_bad && any_hit;
  end

  // Miss FSM next state and memory-side handshake outputs.
  always_comb begin
    state_nxt    = state;
    o_stall_req  = (state != IDLE);
    o_tlb_req    = 1'b0;
    o_refill_req = 1'b0;
    o_replay     = 1'b0;
    case (state)
      IDLE: begin
        o_stall_req = tlb_miss || cache_miss;
        if (tlb_miss) begin
          state_nxt = TLB_WAIT;
        end else if (cache_miss) begin
          state_nxt = REFILL_REQ;
        end
      end
      TLB_WAIT: begin
        o_tlb_req = 1'b1;
        if (i_flush) begin
          state_nxt = i_tlb_done ? IDLE : DRAIN;
        end else if (i_tlb_done) begin
          state_nxt = REPLAY;
        end
      end
      REFILL_REQ: begin
        o_refill_req = 1'b1;
        if (i_flush) begin
          state_nxt = (!i_refill_ack || i_refill_done) ? IDLE : DRAIN;
        end else if (i_refill_ack) begin
          state_nxt = i_refill_done ? REPLAY : REFILL_WAIT;
        end
      end
      REFILL_WAIT: begin
        if (i_flush) begin
          state_nxt = i_refill_done ? IDLE : DRAIN;
        end else if (i_refill_done) begin
          state_nxt = REPLAY;
        end
      end
      REPLAY: begin
        o_replay  = !i_flush;
        state_nxt = IDLE;
      end
      DRAIN: begin
        // Only one request can be outstanding, so either done pulse closes it.
        if (i_tlb_done || i_refill_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, decode-facing output register and miss bookkeeping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_instr       <= '0;
      o_except      <= 1'b0;
      o_except_code <= 2'd0;
      o_miss_addr   <= '0;
      o_replay_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (i_flush) begin
        o_valid <= 1'b0;
      end else if (!i_stall) begin
        o_valid <= hit || misalign || page_fault;
        if (hit || misalign || page_fault) begin
          o_pc          <= i_pc;
          o_instr       <= hit ? hit_data : '0;
          o_except      <= !hit;
          o_except_code <= page_fault ? 2'd1 : 2'd0;
        end
      end
      if (tlb_miss) begin
        o_miss_addr <= i_pc;
        o_replay_pc <= i_pc;
      end else if (cache_miss) begin
        o_miss_addr <= {ptag, i_pc[OFF_WIDTH-1:0]};
        o_replay_pc <= i_pc;
      end
    end
  end

endmodule
